commit_trace_buffer: RTL and testbench

- Synthesizable in-design commit tracer for the sccomp_dataflow CPU family.
- Watches the fetch PC. Whenever the PC changes, it records the previous PC, the previous instruction and a snapshot of the register file.
- Records are queued in a DEPTH-deep record FIFO and drained as a serial word stream over a valid/ready port, so trace capture is available on hardware as well as in simulation.
- Adds parametrised width, register count and depth, a selectable drop or overwrite overflow mode, an enable, and drop accounting.

---
 rtl/commit_trace_buffer.sv | 168 ++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit tracer: records {prev pc, prev inst, register snapshot} whenever the fetch PC
// changes, queues the records in a FIFO and streams them out one word at a time.
module commit_trace_buffer #(
  parameter int              XLEN      = 32,
  parameter int              NREG      = 32,
  parameter int              DEPTH     = 16,
  parameter int              MODE_WRAP = 0,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h00400000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [XLEN-1:0]              pc,
  input  logic [XLEN-1:0]              inst,
  input  logic [NREG*XLEN-1:0]         regs_flat,
  output logic [XLEN-1:0]              out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(NREG+2)-1:0]    out_idx,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);

  localparam int NW    = NREG + 2;
  localparam int REC_W = NW * XLEN;
  localparam int IW    = $clog2(NW);
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  localparam logic [IW-1:0] LAST_IDX = IW'(NREG + 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [XLEN-1:0]  pc_pre;
  logic [XLEN-1:0]  inst_pre;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [0:0]       state;
  logic [REC_W-1:0] shadow;

  logic [REC_W-1:0] rec_new;
  logic [REC_W-1:0] head_rec;
  logic             rec_fire;
  logic             push_req;
  logic             full;
  logic             last_hs;
  logic             pop;
  logic             push_write;
  logic             push_lost;
  logic             wrap_adv;
  logic [IW-1:0]    next_idx;

  // Word 0 sits in the low bits so the word index maps straight onto the record layout.
  assign rec_new  = {regs_flat, inst_pre, pc_pre};
  assign head_rec = mem[rd_ptr];

  function automatic logic [XLEN-1:0] word_sel(input logic [REC_W-1:0] rec,
                                               input logic [IW-1:0]    sel);
    word_sel = '0;
    for (int w = 0; w < NW; w++) begin
      if (sel == IW'(w)) word_sel = rec[w*XLEN +: XLEN];
    end
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rec_fire   = 1'b0;
    push_req   = 1'b0;
    full       = 1'b0;
    last_hs    = 1'b0;
    pop        = 1'b0;
    push_write = 1'b0;
    push_lost  = 1'b0;
    wrap_adv   = 1'b0;
    next_idx   = out_idx + IW'(1);

    rec_fire = (pc != pc_pre);
    push_req = en && rec_fire;
    full     = (occupancy == OCC_FULL);
    last_hs  = out_valid && out_ready && out_last;
    pop      = (occupancy != '0) && ((state == ST_IDLE) || last_hs);

    // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
    push_write = push_req && (!full || pop || (MODE_WRAP != 0));
    push_lost  = push_req && full && !pop;
    wrap_adv   = push_lost && (MODE_WRAP != 0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_pre    <= RESET_PC;
      inst_pre  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (rec_fire) begin
        pc_pre   <= pc;
        inst_pre <= inst;
      end
      if (push_write)      wr_ptr <= wr_ptr + PW'(1);
      if (pop || wrap_adv) rd_ptr <= rd_ptr + PW'(1);

      if (push_write && !pop && !wrap_adv) occupancy <= occupancy + OW'(1);
      else if (pop && !push_write)         occupancy <= occupancy - OW'(1);

      if (push_lost) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // NOTE: the record storage has no reset; the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push_write) mem[wr_ptr] <= rec_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else if (state == ST_IDLE) begin
      if (pop) begin
        shadow    <= head_rec;
        out_data  <= head_rec[XLEN-1:0];
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        out_idx   <= '0;
        state     <= ST_SEND;
      end
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        if (pop) begin
          // Back-to-back: the next record starts on the same edge the last word leaves.
          shadow    <= head_rec;
          out_data  <= head_rec[XLEN-1:0];
          out_last  <= 1'b0;
          out_idx   <= '0;
        end else begin
          out_data  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_idx   <= '0;
          state     <= ST_IDLE;
        end
      end else begin
        out_idx  <= next_idx;
        out_data <= word_sel(shadow, next_idx);
        out_last <= (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: one drop-mode and one wrap-mode instance
// (NREG = 4, DEPTH = 4) share stimulus; each scenario task checks its own outputs.
module tb_commit_trace_buffer;

  localparam logic [31:0] RST_PC = 32'h00400000;

  logic         clk;
  logic         reset;
  logic         en;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic [127:0] regs_flat;
  logic         out_ready;

  logic [31:0]  d_data, w_data;
  logic         d_valid, w_valid;
  logic         d_last, w_last;
  logic [2:0]   d_idx, w_idx;
  logic [2:0]   d_occ, w_occ;
  logic         d_ovf, w_ovf;
  logic [15:0]  d_drop, w_drop;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] got_data[$];
  logic [2:0]  got_idx[$];
  logic        got_last[$];
  int          got_span;
  bit          timed_out;

  commit_trace_buffer #(.XLEN(32), .NREG(4), .DEPTH(4), .MODE_WRAP(0), .RESET_PC(RST_PC)) dut_drop (
    .clk(clk), .reset(reset), .en(en), .pc(pc), .inst(inst), .regs_flat(regs_flat),
    .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready), .out_last(d_last),
    .out_idx(d_idx), .occupancy(d_occ), .overflow(d_ovf), .drop_cnt(d_drop)
  );

  commit_trace_buffer #(.XLEN(32), .NREG(4), .DEPTH(4), .MODE_WRAP(1), .RESET_PC(RST_PC)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .pc(pc), .inst(inst), .regs_flat(regs_flat),
    .out_data(w_data), .out_valid(w_valid), .out_ready(out_ready), .out_last(w_last),
    .out_idx(w_idx), .occupancy(w_occ), .overflow(w_ovf), .drop_cnt(w_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_regs(input logic [31:0] base);
    for (int j = 0; j < 4; j++) regs_flat[j*32 +: 32] = base + 32'(j);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pc    = RST_PC;
    inst  = 32'hDEAD0000;
    set_regs(32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Gathers n words from one instance; caller must sit at a negedge with out_ready held at 1.
  task automatic collect(input bit from_wrap, input int n, input int budget);
    int first;
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    first     = -1;
    got_span  = 0;
    timed_out = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (from_wrap ? w_valid : d_valid) begin
        if (first < 0) first = c;
        got_data.push_back(from_wrap ? w_data : d_data);
        got_idx.push_back(from_wrap ? w_idx : d_idx);
        got_last.push_back(from_wrap ? w_last : d_last);
        if (got_data.size() == n) begin
          got_span = c - first + 1;
          return;
        end
      end
      @(negedge clk);
    end
    timed_out = 1'b1;
  endtask

  // Word w of record k in the seven-change drop/wrap sequence.
  function automatic logic [31:0] seq_word(input int k, input int w);
    if (w == 0) return RST_PC + 32'(4 * (k - 1));
    if (w == 1) return (k == 1) ? 32'h0 : (32'hA0000000 | 32'(k - 1));
    return 32'(k * 16 + (w - 2));
  endfunction

  task automatic test_reset();
    en        = 1'b1;
    out_ready = 1'b1;
    reset     = 1'b1;
    pc        = RST_PC;
    inst      = 32'hDEAD0000;
    set_regs(32'h0);
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", d_valid); end
    n_vec++; if (d_last  !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", d_last); end
    n_vec++; if (d_idx   !== 3'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", d_idx); end
    n_vec++; if (d_data  !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", d_data); end
    n_vec++; if (d_occ   !== 3'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", d_occ); end
    n_vec++; if (d_ovf   !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", d_ovf); end
    n_vec++; if (d_drop  !== 16'h0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", d_drop); end
    n_vec++; if (w_valid !== 1'b0 || w_occ !== 3'd0) begin n_bad++; $display("FAIL reset_wrap: got valid %b occ %0d want 0 0", w_valid, w_occ); end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // pc equals RESET_PC, so leaving reset must not create a record
    n_vec++; if (d_valid !== 1'b0 || d_occ !== 3'd0) begin n_bad++; $display("FAIL reset_no_record: got valid %b occ %0d want 0 0", d_valid, d_occ); end
  endtask

  task automatic test_basic();
    logic [31:0] exp [6];
    exp = '{32'h00400000, 32'h0, 32'd1, 32'd2, 32'd3, 32'd4};
    pc   = 32'h00400004;
    inst = 32'h8C080004;
    set_regs(32'd1);
    @(negedge clk);
    n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat1_valid: got %b want 0", d_valid); end
    n_vec++; if (d_occ !== 3'd1) begin n_bad++; $display("FAIL basic_lat1_occ: got %0d want 1", d_occ); end
    @(negedge clk);
    n_vec++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL basic_lat2_valid: got %b want 1", d_valid); end
    n_vec++; if (d_occ !== 3'd0) begin n_bad++; $display("FAIL basic_lat2_occ: got %0d want 0", d_occ); end
    collect(1'b0, 6, 20);
    n_vec++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %0d words want 6", got_data.size()); end
    n_vec++; if (got_span !== 6) begin n_bad++; $display("FAIL basic_span: got %0d cycles want 6", got_span); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_vec++;
      if (got_data[i] !== exp[i] || got_idx[i] !== 3'(i) || got_last[i] !== (i == 5)) begin
        n_bad++;
        $display("FAIL basic_w%0d: got data %h idx %0d last %b want %h %0d %b",
                 i, got_data[i], got_idx[i], got_last[i], exp[i], i, (i == 5));
      end
    end
    @(negedge clk);
    n_vec++; if (d_valid !== 1'b0 || d_idx !== 3'd0) begin n_bad++; $display("FAIL basic_idle: got valid %b idx %0d want 0 0", d_valid, d_idx); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [6];
    int seen;
    int widx;
    int cyc;
    exp  = '{32'h00400004, 32'h8C080004, 32'd10, 32'd11, 32'd12, 32'd13};
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (d_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL stall_quiet: got %0d valid cycles want 0", seen); end
    out_ready = 1'b0;
    pc   = 32'h00400008;
    inst = 32'h8C090008;
    set_regs(32'd10);
    widx = 0;
    cyc  = 0;
    while (widx < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (d_valid) begin
        n_vec++;
        if (d_data !== exp[widx] || d_idx !== 3'(widx) || d_last !== (widx == 5)) begin
          n_bad++;
          $display("FAIL bp_w%0d: got data %h idx %0d last %b want %h %0d %b",
                   widx, d_data, d_idx, d_last, exp[widx], widx, (widx == 5));
        end
        out_ready = (cyc % 2) == 1;
        if (out_ready) widx++;
      end
    end
    n_vec++; if (widx !== 6) begin n_bad++; $display("FAIL bp_count: got %0d words want 6", widx); end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL bp_single_record: got %0d extra valid cycles want 0", seen); end
  endtask

  task automatic drive_seven_changes();
    for (int k = 1; k <= 7; k++) begin
      pc   = RST_PC + 32'(4 * k);
      inst = 32'hA0000000 | 32'(k);
      set_regs(32'(k * 16));
      @(negedge clk);
    end
  endtask

  task automatic test_drop_mode();
    int recs [5];
    recs      = '{1, 2, 3, 4, 5};
    en        = 1'b1;
    out_ready = 1'b0;
    apply_reset();
    drive_seven_changes();
    n_vec++; if (d_occ !== 3'd4) begin n_bad++; $display("FAIL drop_occ: got %0d want 4", d_occ); end
    n_vec++; if (d_drop !== 16'd2) begin n_bad++; $display("FAIL drop_cnt: got %0d want 2", d_drop); end
    n_vec++; if (d_ovf !== 1'b1) begin n_bad++; $display("FAIL drop_ovf: got %b want 1", d_ovf); end
    n_vec++; if (d_valid !== 1'b1 || d_data !== RST_PC) begin n_bad++; $display("FAIL drop_shadow: got valid %b data %h want 1 %h", d_valid, d_data, RST_PC); end
    out_ready = 1'b1;
    collect(1'b0, 30, 80);
    n_vec++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL drop_timeout: got %0d words want 30", got_data.size()); end
    n_vec++; if (got_span !== 30) begin n_bad++; $display("FAIL drop_back_to_back: got %0d cycles want 30", got_span); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_vec++;
      if (got_data[i] !== seq_word(recs[i/6], i % 6) || got_idx[i] !== 3'(i % 6) || got_last[i] !== ((i % 6) == 5)) begin
        n_bad++;
        $display("FAIL drop_w%0d: got data %h idx %0d last %b want %h %0d %b",
                 i, got_data[i], got_idx[i], got_last[i], seq_word(recs[i/6], i % 6), i % 6, ((i % 6) == 5));
      end
    end
    @(negedge clk);
    n_vec++; if (d_valid !== 1'b0 || d_occ !== 3'd0) begin n_bad++; $display("FAIL drop_empty: got valid %b occ %0d want 0 0", d_valid, d_occ); end
    n_vec++; if (d_ovf !== 1'b1) begin n_bad++; $display("FAIL drop_ovf_sticky: got %b want 1", d_ovf); end
  endtask

  task automatic test_wrap_mode();
    int recs [5];
    recs      = '{1, 4, 5, 6, 7};
    en        = 1'b1;
    out_ready = 1'b0;
    apply_reset();
    drive_seven_changes();
    n_vec++; if (w_occ !== 3'd4) begin n_bad++; $display("FAIL wrap_occ: got %0d want 4", w_occ); end
    n_vec++; if (w_drop !== 16'd2) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 2", w_drop); end
    n_vec++; if (w_ovf !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf: got %b want 1", w_ovf); end
    out_ready = 1'b1;
    collect(1'b1, 30, 80);
    n_vec++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout: got %0d words want 30", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_vec++;
      if (got_data[i] !== seq_word(recs[i/6], i % 6) || got_idx[i] !== 3'(i % 6)) begin
        n_bad++;
        $display("FAIL wrap_w%0d: got data %h idx %0d want %h %0d",
                 i, got_data[i], got_idx[i], seq_word(recs[i/6], i % 6), i % 6);
      end
    end
    @(negedge clk);
    n_vec++; if (w_valid !== 1'b0 || w_occ !== 3'd0) begin n_bad++; $display("FAIL wrap_empty: got valid %b occ %0d want 0 0", w_valid, w_occ); end
  endtask

  task automatic test_enable();
    logic [31:0] exp [6];
    int seen;
    exp       = '{32'h00400108, 32'hB0000003, 32'h50, 32'h51, 32'h52, 32'h53};
    en        = 1'b0;
    out_ready = 1'b1;
    apply_reset();
    seen = 0;
    for (int k = 1; k <= 3; k++) begin
      pc   = 32'h00400100 + 32'(4 * (k - 1));
      inst = 32'hB0000000 | 32'(k);
      set_regs(32'(k * 16));
      @(negedge clk);
      if (d_valid || d_occ != 3'd0) seen++;
    end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL en_gated: got %0d active cycles want 0", seen); end
    en   = 1'b1;
    pc   = 32'h0040010C;
    inst = 32'hB0000004;
    set_regs(32'h50);
    @(negedge clk);
    collect(1'b0, 6, 20);
    n_vec++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL en_timeout: got %0d words want 6", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      n_vec++;
      if (got_data[i] !== exp[i]) begin n_bad++; $display("FAIL en_w%0d: got %h want %h", i, got_data[i], exp[i]); end
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL en_single_record: got %0d extra valid cycles want 0", seen); end
  endtask

  task automatic test_reset_midread();
    bit found;
    en        = 1'b1;
    out_ready = 1'b1;
    apply_reset();
    pc   = 32'h00400200;
    inst = 32'hC0000001;
    set_regs(32'h60);
    @(negedge clk);
    pc   = 32'h00400204;
    inst = 32'hC0000002;
    @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (d_valid && d_idx == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    n_vec++; if (found !== 1'b1) begin n_bad++; $display("FAIL midrd_reach_idx3: got %b want 1", found); end
    n_vec++; if (d_occ !== 3'd1) begin n_bad++; $display("FAIL midrd_occ_before: got %0d want 1", d_occ); end
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (d_valid !== 1'b0 || d_last !== 1'b0) begin n_bad++; $display("FAIL midrd_async_valid: got valid %b last %b want 0 0", d_valid, d_last); end
    n_vec++; if (d_idx !== 3'd0 || d_data !== 32'h0) begin n_bad++; $display("FAIL midrd_async_word: got idx %0d data %h want 0 0", d_idx, d_data); end
    n_vec++; if (d_occ !== 3'd0 || d_drop !== 16'h0) begin n_bad++; $display("FAIL midrd_async_occ: got occ %0d drop %0d want 0 0", d_occ, d_drop); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    collect(1'b0, 6, 20);
    n_vec++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL midrd_timeout: got %0d words want 6", got_data.size()); end
    if (got_data.size() >= 3) begin
      n_vec++; if (got_data[0] !== RST_PC) begin n_bad++; $display("FAIL midrd_pc: got %h want %h", got_data[0], RST_PC); end
      n_vec++; if (got_data[1] !== 32'h0) begin n_bad++; $display("FAIL midrd_inst: got %h want 0", got_data[1]); end
      n_vec++; if (got_data[2] !== 32'h60) begin n_bad++; $display("FAIL midrd_reg0: got %h want 60", got_data[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drop_mode();
    test_wrap_mode();
    test_enable();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
